// File: rtl/me_memory_loader.sv
// Streams one reference block plus search window into ME memories, runs the core, returns min SAD.
// Optional watchdog on the WAIT phase: define ME_LOADER_TIMEOUT_EN.
module me_memory_loader #(
   parameter int DATA_WIDTH      = 8,
   parameter int SW_MEMORY_DEPTH = 961,
   parameter int RB_MEMORY_DEPTH = 256,
   parameter int MAX_DATA_WIDTH  = 16,
   parameter int TIMEOUT_CYCLES  = 65535
) (
   input  logic                               in_clk,
   input  logic                               in_rst,
   input  logic                               in_start,
   input  logic                               in_pix_valid,
   output logic                               out_pix_ready,
   input  logic [DATA_WIDTH-1:0]              in_pix_data,
   output logic                               out_rb_write_en,
   output logic [$clog2(RB_MEMORY_DEPTH)-1:0] out_rb_write_addr,
   output logic [DATA_WIDTH-1:0]              out_rb_write_data,
   output logic                               out_sw_write_en,
   output logic [$clog2(SW_MEMORY_DEPTH)-1:0] out_sw_write_addr,
   output logic [DATA_WIDTH-1:0]              out_sw_write_data,
   output logic                               out_me_enable,
   input  logic [MAX_DATA_WIDTH-1:0]          in_min_SAD,
   input  logic                               in_DONE,
   output logic                               out_result_valid,
   input  logic                               in_result_ready,
   output logic [MAX_DATA_WIDTH-1:0]          out_result_SAD,
   output logic                               out_busy,
   output logic                               out_timeout
);

   localparam int RB_AW = $clog2(RB_MEMORY_DEPTH);
   localparam int SW_AW = $clog2(SW_MEMORY_DEPTH);
   localparam int CW    = (SW_AW > RB_AW) ? SW_AW : RB_AW;
   localparam logic [CW-1:0] RB_LAST = CW'(RB_MEMORY_DEPTH - 1);
   localparam logic [CW-1:0] SW_LAST = CW'(SW_MEMORY_DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_RB, S_LOAD_SW, S_START, S_WAIT, S_RESULT
   } state_t;

   state_t                    state_q, state_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic                      rb_we_q, rb_we_d;
   logic [RB_AW-1:0]          rb_addr_q, rb_addr_d;
   logic [DATA_WIDTH-1:0]     rb_data_q, rb_data_d;
   logic                      sw_we_q, sw_we_d;
   logic [SW_AW-1:0]          sw_addr_q, sw_addr_d;
   logic [DATA_WIDTH-1:0]     sw_data_q, sw_data_d;
   logic                      me_en_q, me_en_d;
   logic                      res_v_q, res_v_d;
   logic [MAX_DATA_WIDTH-1:0] sad_q, sad_d;
   logic                      pix_ready;
   logic                      accept;

`ifdef ME_LOADER_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WW-1:0] TO_LAST = WW'(TIMEOUT_CYCLES - 1);
   logic [WW-1:0] wcnt_q, wcnt_d;
   logic          to_q, to_d;
`endif

   assign pix_ready = (state_q == S_LOAD_RB) || (state_q == S_LOAD_SW);
   assign accept    = in_pix_valid & pix_ready;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rb_we_d   = 1'b0;
      rb_addr_d = '0;
      rb_data_d = '0;
      sw_we_d   = 1'b0;
      sw_addr_d = '0;
      sw_data_d = '0;
      me_en_d   = me_en_q;
      res_v_d   = res_v_q;
      sad_d     = sad_q;
`ifdef ME_LOADER_TIMEOUT_EN
      wcnt_d    = wcnt_q;
      to_d      = to_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (in_start) begin
               state_d = S_LOAD_RB;
               cnt_d   = '0;
`ifdef ME_LOADER_TIMEOUT_EN
               to_d    = 1'b0;
`endif
            end
         end
         S_LOAD_RB: begin
            if (accept) begin
               rb_we_d   = 1'b1;
               rb_addr_d = cnt_q[RB_AW-1:0];
               rb_data_d = in_pix_data;
               if (cnt_q == RB_LAST) begin
                  state_d = S_LOAD_SW;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_LOAD_SW: begin
            if (accept) begin
               sw_we_d   = 1'b1;
               sw_addr_d = cnt_q[SW_AW-1:0];
               sw_data_d = in_pix_data;
               if (cnt_q == SW_LAST) begin
                  state_d = S_START;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         // One idle cycle lets the final SW write land before the core runs.
         S_START: begin
            state_d = S_WAIT;
            me_en_d = 1'b1;
`ifdef ME_LOADER_TIMEOUT_EN
            wcnt_d  = '0;
`endif
         end
         S_WAIT: begin
            if (in_DONE) begin
               state_d = S_RESULT;
               sad_d   = in_min_SAD;
               me_en_d = 1'b0;
               res_v_d = 1'b1;
            end
`ifdef ME_LOADER_TIMEOUT_EN
            else if (wcnt_q == TO_LAST) begin
               state_d = S_RESULT;
               sad_d   = '1;
               me_en_d = 1'b0;
               res_v_d = 1'b1;
               to_d    = 1'b1;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
`endif
         end
         S_RESULT: begin
            if (in_result_ready) begin
               state_d = S_IDLE;
               res_v_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         rb_we_q   <= 1'b0;
         rb_addr_q <= '0;
         rb_data_q <= '0;
         sw_we_q   <= 1'b0;
         sw_addr_q <= '0;
         sw_data_q <= '0;
         me_en_q   <= 1'b0;
         res_v_q   <= 1'b0;
         sad_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rb_we_q   <= rb_we_d;
         rb_addr_q <= rb_addr_d;
         rb_data_q <= rb_data_d;
         sw_we_q   <= sw_we_d;
         sw_addr_q <= sw_addr_d;
         sw_data_q <= sw_data_d;
         me_en_q   <= me_en_d;
         res_v_q   <= res_v_d;
         sad_q     <= sad_d;
      end
   end

`ifdef ME_LOADER_TIMEOUT_EN
   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         wcnt_q <= '0;
         to_q   <= 1'b0;
      end else begin
         wcnt_q <= wcnt_d;
         to_q   <= to_d;
      end
   end
   assign out_timeout = to_q;
`else
   assign out_timeout = 1'b0;
`endif

   assign out_pix_ready     = pix_ready;
   assign out_rb_write_en   = rb_we_q;
   assign out_rb_write_addr = rb_addr_q;
   assign out_rb_write_data = rb_data_q;
   assign out_sw_write_en   = sw_we_q;
   assign out_sw_write_addr = sw_addr_q;
   assign out_sw_write_data = sw_data_q;
   assign out_me_enable     = me_en_q;
   assign out_result_valid  = res_v_q;
   assign out_result_SAD    = sad_q;
   assign out_busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_me_memory_loader.sv
// Directed bench for me_memory_loader: load ordering, handshakes, reset, watchdog.
module tb_me_memory_loader;

   localparam int DW  = 8;
   localparam int SWD = 961;
   localparam int RBD = 256;
   localparam int MW  = 16;
   localparam int NB  = RBD + SWD;

   logic          in_clk = 1'b0;
   logic          in_rst = 1'b0;
   logic          in_start = 1'b0;
   logic          in_pix_valid = 1'b0;
   logic          out_pix_ready;
   logic [DW-1:0] in_pix_data = '0;
   logic          out_rb_write_en;
   logic [7:0]    out_rb_write_addr;
   logic [DW-1:0] out_rb_write_data;
   logic          out_sw_write_en;
   logic [9:0]    out_sw_write_addr;
   logic [DW-1:0] out_sw_write_data;
   logic          out_me_enable;
   logic [MW-1:0] in_min_SAD = '0;
   logic          in_DONE = 1'b0;
   logic          out_result_valid;
   logic          in_result_ready = 1'b0;
   logic [MW-1:0] out_result_SAD;
   logic          out_busy;
   logic          out_timeout;

   me_memory_loader #(
      .DATA_WIDTH(DW), .SW_MEMORY_DEPTH(SWD), .RB_MEMORY_DEPTH(RBD),
      .MAX_DATA_WIDTH(MW), .TIMEOUT_CYCLES(100)
   ) dut (
      .in_clk(in_clk), .in_rst(in_rst), .in_start(in_start),
      .in_pix_valid(in_pix_valid), .out_pix_ready(out_pix_ready),
      .in_pix_data(in_pix_data),
      .out_rb_write_en(out_rb_write_en), .out_rb_write_addr(out_rb_write_addr),
      .out_rb_write_data(out_rb_write_data),
      .out_sw_write_en(out_sw_write_en), .out_sw_write_addr(out_sw_write_addr),
      .out_sw_write_data(out_sw_write_data),
      .out_me_enable(out_me_enable), .in_min_SAD(in_min_SAD), .in_DONE(in_DONE),
      .out_result_valid(out_result_valid), .in_result_ready(in_result_ready),
      .out_result_SAD(out_result_SAD), .out_busy(out_busy), .out_timeout(out_timeout)
   );

   always #5 in_clk = ~in_clk;

   typedef struct {
      int addr;
      int data;
      int cyc;
   } wr_t;

   wr_t rb_q[$];
   wr_t sw_q[$];
   int  cyc = 0;
   int  acc_n = 0;
   int  zero_err = 0;
   int  n_checks = 0;
   int  n_fail = 0;

   logic [56:0] all_outs;
   assign all_outs = {out_pix_ready, out_rb_write_en, out_rb_write_addr,
                      out_rb_write_data, out_sw_write_en, out_sw_write_addr,
                      out_sw_write_data, out_me_enable, out_result_valid,
                      out_result_SAD, out_busy, out_timeout};

   always @(posedge in_clk) begin
      cyc <= cyc + 1;
      if (in_pix_valid && out_pix_ready) acc_n <= acc_n + 1;
   end

   always @(negedge in_clk) begin
      if (out_rb_write_en)
         rb_q.push_back('{int'(out_rb_write_addr), int'(out_rb_write_data), cyc});
      else if (out_rb_write_addr != 0 || out_rb_write_data != 0)
         zero_err <= zero_err + 1;
      if (out_sw_write_en)
         sw_q.push_back('{int'(out_sw_write_addr), int'(out_sw_write_data), cyc});
      else if (out_sw_write_addr != 0 || out_sw_write_data != 0)
         zero_err <= zero_err + 1;
   end

   // Expected write stream: RB addr i data i, then SW addr j data j mod 256.
   function automatic int seq_errs(input int rb0, input int sw0);
      int e = 0;
      if (rb_q.size() - rb0 != RBD) e++;
      else
         for (int i = 0; i < RBD; i++)
            if (rb_q[rb0+i].addr != i || rb_q[rb0+i].data != (i % 256)) e++;
      if (sw_q.size() - sw0 != SWD) e++;
      else
         for (int j = 0; j < SWD; j++)
            if (sw_q[sw0+j].addr != j || sw_q[sw0+j].data != (j % 256)) e++;
      return e;
   endfunction

   task automatic begin_job();
      in_start = 1'b1;
      @(negedge in_clk);
      in_start = 1'b0;
   endtask

   task automatic feed(input bit gaps, input bit poke, input int n, output int got);
      int i = 0;
      int guard = 0;
      while (i < n && guard < 20000) begin
         in_pix_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         in_pix_data  = i[7:0];
         in_start     = poke && (i == 10);
         in_DONE      = poke && (i == 10);
         if (in_pix_valid && out_pix_ready) i++;
         guard++;
         @(negedge in_clk);
      end
      in_pix_valid = 1'b0;
      in_start     = 1'b0;
      in_DONE      = 1'b0;
      got = i;
   endtask

   task automatic finish_job(input logic [MW-1:0] sad);
      in_min_SAD = sad;
      in_DONE = 1'b1;
      @(negedge in_clk);
      in_DONE = 1'b0;
      in_result_ready = 1'b1;
      @(negedge in_clk);
      in_result_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge in_clk);
      n_checks++;
      if (all_outs !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h want 0", all_outs);
      end
      in_rst = 1'b1;
      repeat (2) @(negedge in_clk);
      n_checks++;
      if (out_busy !== 1'b0 || out_pix_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset: busy=%b ready=%b want 0 0", out_busy, out_pix_ready);
      end
   endtask

   task automatic test_back_to_back();
      int rb0 = rb_q.size();
      int sw0 = sw_q.size();
      int a0  = acc_n;
      int got, e;
      begin_job();
      n_checks++;
      if (out_pix_ready !== 1'b1 || out_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL start_ready: ready=%b busy=%b want 1 1", out_pix_ready, out_busy);
      end
      feed(1'b0, 1'b0, NB, got);
      n_checks++;
      if (got != NB) begin
         n_fail++;
         $display("FAIL b2b_beats: accepted %0d want %0d", got, NB);
      end
      n_checks++;
      if (out_me_enable !== 1'b0) begin
         n_fail++;
         $display("FAIL enable_start_cycle: got %b want 0", out_me_enable);
      end
      @(negedge in_clk);
      n_checks++;
      if (out_me_enable !== 1'b1) begin
         n_fail++;
         $display("FAIL enable_rise: got %b want 1", out_me_enable);
      end
      e = seq_errs(rb0, sw0);
      n_checks++;
      if (e != 0) begin
         n_fail++;
         $display("FAIL b2b_writes: %0d bad write entries, want 0", e);
      end
      n_checks++;
      if (acc_n - a0 != NB) begin
         n_fail++;
         $display("FAIL b2b_accepts: got %0d want %0d", acc_n - a0, NB);
      end
      n_checks++;
      if (rb_q.size() - rb0 < RBD || sw_q.size() - sw0 < 1) begin
         n_fail++;
         $display("FAIL rb_sw_boundary: write queues short");
      end else if (sw_q[sw0].cyc != rb_q[rb0+RBD-1].cyc + 1) begin
         n_fail++;
         $display("FAIL rb_sw_boundary: sw first cyc %0d want %0d",
                  sw_q[sw0].cyc, rb_q[rb0+RBD-1].cyc + 1);
      end
`ifdef ME_LOADER_TIMEOUT_EN
      repeat (99) @(negedge in_clk);
      n_checks++;
      if (out_me_enable !== 1'b1 || out_result_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL wait_100th: en=%b valid=%b want 1 0", out_me_enable, out_result_valid);
      end
      @(negedge in_clk);
      n_checks++;
      if (out_timeout !== 1'b1 || out_result_SAD !== 16'hFFFF ||
          out_result_valid !== 1'b1 || out_me_enable !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout: to=%b sad=%h valid=%b en=%b want 1 ffff 1 0",
                  out_timeout, out_result_SAD, out_result_valid, out_me_enable);
      end
      in_result_ready = 1'b1;
      @(negedge in_clk);
      in_result_ready = 1'b0;
      n_checks++;
      if (out_busy !== 1'b0 || out_timeout !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_sticky: busy=%b to=%b want 0 1", out_busy, out_timeout);
      end
`else
      repeat (150) @(negedge in_clk);
      n_checks++;
      if (out_me_enable !== 1'b1 || out_timeout !== 1'b0 || out_result_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL wait_hold: en=%b to=%b valid=%b want 1 0 0",
                  out_me_enable, out_timeout, out_result_valid);
      end
      finish_job(16'h0001);
`endif
   endtask

   task automatic test_result();
      int got;
      begin_job();
      n_checks++;
      if (out_timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_clear: got %b want 0", out_timeout);
      end
      feed(1'b0, 1'b0, NB, got);
      repeat (2) @(negedge in_clk);
      in_min_SAD = 16'h1234;
      in_DONE = 1'b1;
      @(negedge in_clk);
      in_DONE = 1'b0;
      n_checks++;
      if (out_result_valid !== 1'b1 || out_result_SAD !== 16'h1234 || out_me_enable !== 1'b0) begin
         n_fail++;
         $display("FAIL done_capture: valid=%b sad=%h en=%b want 1 1234 0",
                  out_result_valid, out_result_SAD, out_me_enable);
      end
      in_min_SAD = 16'h5555;
      in_DONE = 1'b1;
      repeat (3) @(negedge in_clk);
      in_DONE = 1'b0;
      n_checks++;
      if (out_result_valid !== 1'b1 || out_result_SAD !== 16'h1234 || out_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL result_hold: valid=%b sad=%h busy=%b want 1 1234 1",
                  out_result_valid, out_result_SAD, out_busy);
      end
      in_result_ready = 1'b1;
      in_start = 1'b1;
      @(negedge in_clk);
      in_result_ready = 1'b0;
      in_start = 1'b0;
      n_checks++;
      if (out_result_valid !== 1'b0 || out_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL result_ack: valid=%b busy=%b want 0 0", out_result_valid, out_busy);
      end
      @(negedge in_clk);
      n_checks++;
      if (out_busy !== 1'b0 || out_pix_ready !== 1'b0 || out_result_SAD !== 16'h1234) begin
         n_fail++;
         $display("FAIL start_not_sampled: busy=%b ready=%b sad=%h want 0 0 1234",
                  out_busy, out_pix_ready, out_result_SAD);
      end
   endtask

   task automatic test_gaps();
      int rb0 = rb_q.size();
      int sw0 = sw_q.size();
      int a0  = acc_n;
      int got, e;
      begin_job();
      feed(1'b1, 1'b0, NB, got);
      @(negedge in_clk);
      e = seq_errs(rb0, sw0);
      n_checks++;
      if (got != NB || e != 0) begin
         n_fail++;
         $display("FAIL gap_writes: beats %0d bad %0d want %0d 0", got, e, NB);
      end
      n_checks++;
      if (acc_n - a0 != NB || out_me_enable !== 1'b1) begin
         n_fail++;
         $display("FAIL gap_accepts: acc %0d en=%b want %0d 1", acc_n - a0, out_me_enable, NB);
      end
      finish_job(16'h00AA);
   endtask

   task automatic test_ignore();
      int rb0 = rb_q.size();
      int sw0 = sw_q.size();
      int got, e;
      begin_job();
      feed(1'b0, 1'b1, NB, got);
      @(negedge in_clk);
      e = seq_errs(rb0, sw0);
      n_checks++;
      if (got != NB || e != 0) begin
         n_fail++;
         $display("FAIL ignore_writes: beats %0d bad %0d want %0d 0", got, e, NB);
      end
      n_checks++;
      if (out_me_enable !== 1'b1 || out_result_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL ignore_done: en=%b valid=%b want 1 0", out_me_enable, out_result_valid);
      end
      finish_job(16'h0042);
   endtask

   task automatic test_reset_mid_job();
      int rb0, sw0, got, e;
      begin_job();
      feed(1'b0, 1'b0, 300, got);
      in_rst = 1'b0;
      #1;
      n_checks++;
      if (all_outs !== '0) begin
         n_fail++;
         $display("FAIL midjob_reset: got %h want 0", all_outs);
      end
      @(negedge in_clk);
      #1 in_rst = 1'b1;
      @(negedge in_clk);
      rb0 = rb_q.size();
      sw0 = sw_q.size();
      begin_job();
      feed(1'b0, 1'b0, NB, got);
      @(negedge in_clk);
      n_checks++;
      if (rb_q.size() - rb0 < 1) begin
         n_fail++;
         $display("FAIL restart_addr0: no RB write seen");
      end else if (rb_q[rb0].addr != 0 || rb_q[rb0].data != 0) begin
         n_fail++;
         $display("FAIL restart_addr0: addr %0d data %0d want 0 0",
                  rb_q[rb0].addr, rb_q[rb0].data);
      end
      e = seq_errs(rb0, sw0);
      n_checks++;
      if (e != 0) begin
         n_fail++;
         $display("FAIL restart_writes: %0d bad entries want 0", e);
      end
      finish_job(16'h0007);
      n_checks++;
      if (zero_err != 0) begin
         n_fail++;
         $display("FAIL idle_write_ports: %0d nonzero idle samples want 0", zero_err);
      end
   endtask

   initial begin
      @(negedge in_clk);
      test_reset();
      test_back_to_back();
      test_result();
      test_gaps();
      test_ignore();
      test_reset_mid_job();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/me_memory_loader.md
# me_memory_loader

Upstream feeder for the motion estimation core. It accepts one reference block and its search window as a single valid/ready pixel stream, writes them into the reference block and search window memory write ports, and starts the core. It then holds the core enable until completion and returns the minimum SAD through a result handshake. One loader instance drives one motion estimation core.

## Interface
- DATA_WIDTH, 8, pixel width
- SW_MEMORY_DEPTH, 961, search window pixels (31x31)
- RB_MEMORY_DEPTH, 256, reference block pixels (16x16)
- MAX_DATA_WIDTH, 16, SAD width
- TIMEOUT_CYCLES, 65535, watchdog limit; used only with ME_LOADER_TIMEOUT_EN
---
- in_clk  in  1  single clock, rising edge
- in_rst  in  1  asynchronous, active-low reset
- in_start  in  1  begin a new load/compute job
- in_pix_valid  in  1  stream beat valid
- out_pix_ready  out  1  loader accepts a beat
- in_pix_data  in  DATA_WIDTH  stream pixel
- out_rb_write_en  out  1  reference block memory write strobe
- out_rb_write_addr  out  $clog2(RB_MEMORY_DEPTH)  write address
- out_rb_write_data  out  DATA_WIDTH  write data
- out_sw_write_en  out  1  search window memory write strobe
- out_sw_write_addr  out  $clog2(SW_MEMORY_DEPTH)  write address
- out_sw_write_data  out  DATA_WIDTH  write data
- out_me_enable  out  1  core enable, level
- in_min_SAD  in  MAX_DATA_WIDTH  core minimum SAD
- in_DONE  in  1  core completion
- out_result_valid  out  1  result available
- in_result_ready  in  1  consumer takes result
- out_result_SAD  out  MAX_DATA_WIDTH  captured minimum SAD
- out_busy  out  1  state is not IDLE
- out_timeout  out  1  sticky watchdog flag (macro only; otherwise tied 0)

## Operation
- States: IDLE, LOAD_RB, LOAD_SW, START, WAIT, RESULT.
- IDLE: when in_start=1, go to LOAD_RB and clear the address counter. While busy, in_start is ignored.
- out_pix_ready = 1 only in LOAD_RB/LOAD_SW. A beat is accepted on cycle where in_pix_valid & out_pix_ready.
- Stream order: RB_MEMORY_DEPTH reference pixels, then SW_MEMORY_DEPTH search window pixels, each raster order, address 0 upward.
- Accepted beat with address counter a: the write port registers en=1, addr=a, data=in_pix_data on the next edge. The strobe lasts 1 cycle. Write ports are 0 otherwise.
- Last RB beat (a=RB_MEMORY_DEPTH-1): go to LOAD_SW and reset the counter to 0. No bubble is inserted.
- Last SW beat (a=SW_MEMORY_DEPTH-1): go to START. START lasts 1 cycle so the final write lands before enable. Then go to WAIT.
- WAIT: out_me_enable=1 (registered). On in_DONE=1, capture in_min_SAD into out_result_SAD, clear out_me_enable, and go to RESULT.
- in_DONE outside WAIT is ignored.
- RESULT: out_result_valid=1 and out_result_SAD is held stable. When in_result_ready=1, go to IDLE and clear out_result_valid. in_start in that same cycle is not sampled.
- Counters saturate by construction: the address never exceeds depth-1. No wrap occurs inside a job.
- The loader never reads memory contents. Memory contents are not cleared by reset.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, out_result_SAD 0.
- Reset mid-job returns to IDLE immediately and drops out_me_enable. Partially written memory is stale; the next job rewrites all addresses.
- in_start sampled at edge t: out_pix_ready=1 from cycle t+1.
- Write strobe occurs 1 cycle after acceptance.
- Minimum load with valid held high: 1217 cycles. START: 1 cycle. out_me_enable rises 2 cycles after the last accepted beat.
- in_DONE at edge d: out_result_valid=1 and out_me_enable=0 from cycle d+1.
- in_pix_valid low stalls the job indefinitely with no state change.

## Configuration
- ME_LOADER_TIMEOUT_EN defined: a WAIT cycle counter runs. When it reaches TIMEOUT_CYCLES without in_DONE:
  - clear out_me_enable
  - set out_timeout (sticky until reset or next in_start)
  - go to RESULT with out_result_SAD = all ones.
- ME_LOADER_TIMEOUT_EN undefined: no counter. WAIT lasts until in_DONE. out_timeout is tied 0.

## Test plan
- Reset with in_rst=0 mid-LOAD_SW -> all outputs 0 and state IDLE. The next in_start restarts at RB address 0.
- in_start, then 1217 back-to-back beats with data=index mod 256:
  - RB writes addr 0..255 carry data 0..255.
  - SW writes addr 0..960 carry data 0..255 repeating, starting at 0.
  - No gap at the RB/SW boundary.
  - out_me_enable rises 2 cycles after the last beat.
- Random in_pix_valid gaps (50%) -> same write sequence as the back-to-back case. No write occurs without a preceding accept.
- In WAIT, drive in_min_SAD=0x1234 and pulse in_DONE -> next cycle out_result_valid=1, out_result_SAD=0x1234, out_me_enable=0. Valid is held until in_result_ready, then IDLE.
- in_start and in_DONE pulsed during LOAD_RB -> both ignored; the load continues normally.
- With ME_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=100, in_DONE is never asserted -> after 100 WAIT cycles: out_timeout=1, out_result_SAD=0xFFFF, out_result_valid=1.
